// File: rtl/jtcop_mcu_rom.sv
// jtcop_mcu_rom -- ROM fetch stage in front of the HuC6280 protection MCU.
//
// Answers MCU byte fetches from a 32-bit line buffer and refills that buffer
// from the SDRAM ROM slot over the jtframe rom_cs/rom_ok handshake. For the
// Hippodrome game (game_id == HIPPO_ID) every byte has bits 7 and 0 swapped at
// fill time, so the MCU always reads plain opcodes.
//
// Optional build macro: JTCOP_MCU_PREFETCH_EN adds a second line buffer that
// is filled in the background with the line following the current hit.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   game_id             current game; a change invalidates buffered lines
//   mcu_addr, mcu_cs    MCU byte address and ROM select (level)
//   mcu_data, mcu_ok    byte for mcu_addr and its valid flag (combinational)
//   rom_addr, rom_cs    SDRAM line address and request
//   rom_data, rom_ok    SDRAM line (byte n in bits [8n+7:8n]) and valid
module jtcop_mcu_rom #(
  parameter logic [1:0]  HIPPO_ID = 2'd1,
  parameter int unsigned AW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    game_id,
  input  logic [AW-1:0] mcu_addr,
  input  logic          mcu_cs,
  output logic [7:0]    mcu_data,
  output logic          mcu_ok,
  output logic [AW-3:0] rom_addr,
  output logic          rom_cs,
  input  logic [31:0]   rom_data,
  input  logic          rom_ok
);

  localparam int unsigned LW = AW - 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic          rom_cs_q, rom_cs_d;
  logic [LW-1:0] rom_addr_q, rom_addr_d;
  logic [31:0]   line_q, line_d;
  logic [LW-1:0] tag_q, tag_d;
  logic          valid_q, valid_d;
  logic [1:0]    game_q, game_d;

  logic          hit, hit_a;
  logic [31:0]   sel_line;
  logic [31:0]   fill_data;
  logic          game_chg;

`ifdef JTCOP_MCU_PREFETCH_EN
  logic [31:0]   pline_q, pline_d;
  logic [LW-1:0] ptag_q, ptag_d;
  logic          pvalid_q, pvalid_d;
  logic          pf_q, pf_d;      // in-flight fetch targets the prefetch buffer
  logic          hit_b;
  logic [LW-1:0] tag_nxt;
`endif

  function automatic logic [31:0] descramble(input logic [31:0] d);
    logic [31:0] o;
    o = d;
    for (int unsigned i = 0; i < 4; i++) begin
      o[8*i]   = d[8*i+7];
      o[8*i+7] = d[8*i];
    end
    return o;
  endfunction

  assign fill_data = (game_id == HIPPO_ID) ? descramble(rom_data) : rom_data;
  assign game_chg  = (game_id != game_q);
  assign hit_a     = valid_q && (tag_q == mcu_addr[AW-1:2]);

`ifdef JTCOP_MCU_PREFETCH_EN
  assign hit_b    = pvalid_q && (ptag_q == mcu_addr[AW-1:2]);
  assign hit      = hit_a || hit_b;
  assign sel_line = (hit_b && !hit_a) ? pline_q : line_q;
  assign tag_nxt  = tag_q + LW'(1);
`else
  assign hit      = hit_a;
  assign sel_line = line_q;
`endif

  assign mcu_data = sel_line[{mcu_addr[1:0], 3'b000} +: 8];
  assign mcu_ok   = mcu_cs && hit;
  assign rom_addr = rom_addr_q;
  assign rom_cs   = rom_cs_q;

  always_comb begin
    state_d    = state_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    line_d     = line_q;
    tag_d      = tag_q;
    valid_d    = valid_q;
    game_d     = game_id;
`ifdef JTCOP_MCU_PREFETCH_EN
    pline_d    = pline_q;
    ptag_d     = ptag_q;
    pvalid_d   = pvalid_q;
    pf_d       = pf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mcu_cs && !hit) begin
          rom_addr_d = mcu_addr[AW-1:2];
          rom_cs_d   = 1'b1;
          state_d    = ST_ISSUE;
`ifdef JTCOP_MCU_PREFETCH_EN
          pf_d       = 1'b0;
        end else if (mcu_cs && hit && (!pvalid_q || ptag_q != tag_nxt)) begin
          rom_addr_d = tag_nxt;
          rom_cs_d   = 1'b1;
          pf_d       = 1'b1;
          state_d    = ST_ISSUE;
`endif
        end
      end
      // rom_ok may still belong to the previous address here
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rom_ok) begin
          rom_cs_d = 1'b0;
          state_d  = ST_IDLE;
`ifdef JTCOP_MCU_PREFETCH_EN
          if (pf_q) begin
            pline_d  = fill_data;
            ptag_d   = rom_addr_q;
            pvalid_d = 1'b1;
          end else begin
            // old primary line moves to the prefetch slot instead of
            // leaving two copies of the same line
            if (pvalid_q && ptag_q == rom_addr_q) begin
              pline_d  = line_q;
              ptag_d   = tag_q;
              pvalid_d = valid_q;
            end
            line_d  = fill_data;
            tag_d   = rom_addr_q;
            valid_d = 1'b1;
          end
`else
          line_d  = fill_data;
          tag_d   = rom_addr_q;
          valid_d = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // a game change overrides any fill landing on the same edge
    if (game_chg) begin
      valid_d = 1'b0;
`ifdef JTCOP_MCU_PREFETCH_EN
      pvalid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      line_q     <= '0;
      tag_q      <= '0;
      valid_q    <= 1'b0;
      game_q     <= game_id;
`ifdef JTCOP_MCU_PREFETCH_EN
      pline_q    <= '0;
      ptag_q     <= '0;
      pvalid_q   <= 1'b0;
      pf_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      line_q     <= line_d;
      tag_q      <= tag_d;
      valid_q    <= valid_d;
      game_q     <= game_d;
`ifdef JTCOP_MCU_PREFETCH_EN
      pline_q    <= pline_d;
      ptag_q     <= ptag_d;
      pvalid_q   <= pvalid_d;
      pf_q       <= pf_d;
`endif
    end
  end

endmodule

// File: tb/tb_jtcop_mcu_rom.sv
module tb_jtcop_mcu_rom;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  game_id;
  logic [15:0] mcu_addr;
  logic        mcu_cs;
  logic [7:0]  mcu_data;
  logic        mcu_ok;
  logic [13:0] rom_addr;
  logic        rom_cs;
  logic [31:0] rom_data;
  logic        rom_ok;

  int total = 0;
  int bad   = 0;
  bit resp_en;
  int cnt;
  int lat;

  always #5 clk = ~clk;

  jtcop_mcu_rom #(.HIPPO_ID(2'd1), .AW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .game_id  (game_id),
    .mcu_addr (mcu_addr),
    .mcu_cs   (mcu_cs),
    .mcu_data (mcu_data),
    .mcu_ok   (mcu_ok),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_data (rom_data),
    .rom_ok   (rom_ok)
  );

  // ROM contents as seen by the SDRAM model
  function automatic logic [31:0] mem_line(input logic [13:0] l);
    return ((32'(l) + 32'd1) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // byte the MCU must read at address a for game g
  function automatic logic [7:0] model_byte(input logic [15:0] a, input logic [1:0] g);
    int w, sh, b;
    w  = int'(mem_line(a[15:2]));
    sh = int'(a % 16'd4);
    b  = (w >>> (8 * sh)) & 255;
    if (g == 2'd1) b = (b & 126) | ((b & 1) * 128) | (b / 128);
    return 8'(b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock; when enabled, act as the SDRAM: junk rom_ok while idle and in
  // the first request cycle, real data after a random latency
  task automatic step();
    @(posedge clk);
    #1;
    if (resp_en) begin
      if (rom_cs) begin
        cnt++;
        if (cnt == 1) begin
          rom_ok   = 1'($urandom_range(0, 1));
          rom_data = $urandom();
        end else begin
          rom_ok   = (cnt > lat);
          rom_data = rom_ok ? mem_line(rom_addr) : $urandom();
        end
      end else begin
        cnt      = 0;
        lat      = $urandom_range(1, 4);
        rom_ok   = 1'($urandom_range(0, 1));
        rom_data = $urandom();
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  dexp [4];
    logic [15:0] a, prev;
    logic [1:0]  g;
    bit          got;

    dexp = '{8'h81, 8'h4E, 8'h80, 8'h7F};
    rst = 1'b1; game_id = 2'd0; mcu_addr = '0; mcu_cs = 1'b0;
    rom_ok = 1'b0; rom_data = '0; resp_en = 1'b0; cnt = 0; lat = 1;
    step(); step();
    mcu_cs = 1'b1;
    #1;
    chk("rst_rom_cs", 32'(rom_cs), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_ok", 32'(mcu_ok), 32'd0);
    chk("rst_data", 32'(mcu_data), 32'd0);
    mcu_cs = 1'b0; rst = 1'b0;
    step();

`ifndef JTCOP_MCU_PREFETCH_EN
    // cold miss
    mcu_addr = 16'h0006; mcu_cs = 1'b1;
    #1;
    chk("cold_ok_c0", 32'(mcu_ok), 32'd0);
    step();
    chk("cold_rom_cs", 32'(rom_cs), 32'd1);
    chk("cold_rom_addr", 32'(rom_addr), 32'h0001);
    step();
    rom_ok = 1'b1; rom_data = 32'h44332211;
    step();
    rom_ok = 1'b0;
    #1;
    chk("cold_ok_c3", 32'(mcu_ok), 32'd1);
    chk("cold_data", 32'(mcu_data), 32'h33);
    mcu_addr = 16'h0004;
    #1;
    chk("same_line_ok", 32'(mcu_ok), 32'd1);
    chk("same_line_data", 32'(mcu_data), 32'h11);
    step();
    chk("same_line_no_req", 32'(rom_cs), 32'd0);

    // descramble
    game_id = 2'd1; mcu_cs = 1'b0;
    step();
    mcu_addr = 16'h0000; mcu_cs = 1'b1;
    #1;
    chk("dsc_miss", 32'(mcu_ok), 32'd0);
    step();
    rom_ok = 1'b1; rom_data = 32'hFE014E81;
    step();
    step();
    rom_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mcu_addr = 16'(i);
      #1;
      chk("dsc_ok", 32'(mcu_ok), 32'd1);
      chk("dsc_data", 32'(mcu_data), 32'(dexp[i]));
    end

    // stale rom_ok held high through the request
    game_id = 2'd0; mcu_cs = 1'b0;
    step();
    mcu_addr = 16'h0100; mcu_cs = 1'b1; rom_ok = 1'b1; rom_data = 32'hDEADBEEF;
    step();
    chk("stale_cs1", 32'(rom_cs), 32'd1);
    chk("stale_addr", 32'(rom_addr), 32'h0040);
    step();
    chk("stale_cs2", 32'(rom_cs), 32'd1);
    chk("stale_not_taken", 32'(mcu_ok), 32'd0);
    rom_data = 32'h0C0B0A09;
    step();
    rom_ok = 1'b0;
    #1;
    chk("stale_fill_ok", 32'(mcu_ok), 32'd1);
    chk("stale_fill_data", 32'(mcu_data), 32'h09);
    chk("stale_cs_done", 32'(rom_cs), 32'd0);
    mcu_addr = 16'h0103;
    #1;
    chk("stale_tag_data", 32'(mcu_data), 32'h0C);

    // address change mid-fetch
    mcu_addr = 16'h0010;
    step();
    chk("mid_addr1", 32'(rom_addr), 32'h0004);
    step();
    mcu_addr = 16'h2000; rom_ok = 1'b1; rom_data = 32'h11223344;
    #1;
    chk("mid_ok_wait", 32'(mcu_ok), 32'd0);
    step();
    rom_ok = 1'b0;
    #1;
    chk("mid_idle_cs", 32'(rom_cs), 32'd0);
    chk("mid_idle_ok", 32'(mcu_ok), 32'd0);
    mcu_addr = 16'h0010;
    #1;
    chk("mid_old_line_ok", 32'(mcu_ok), 32'd1);
    chk("mid_old_line_data", 32'(mcu_data), 32'h44);
    mcu_addr = 16'h2000;
    step();
    chk("mid_req2_cs", 32'(rom_cs), 32'd1);
    chk("mid_req2_addr", 32'(rom_addr), 32'h0800);
    step();
    rom_ok = 1'b1; rom_data = 32'h55667788;
    step();
    rom_ok = 1'b0;
    #1;
    chk("mid_req2_ok", 32'(mcu_ok), 32'd1);
    chk("mid_req2_data", 32'(mcu_data), 32'h88);

    // invalidate on game change, then reset mid-fetch
    game_id = 2'd1;
    step();
    chk("inv_ok", 32'(mcu_ok), 32'd0);
    step();
    chk("inv_refetch_cs", 32'(rom_cs), 32'd1);
    chk("inv_refetch_addr", 32'(rom_addr), 32'h0800);
    step();
    rst = 1'b1;
    step();
    chk("rstw_cs", 32'(rom_cs), 32'd0);
    chk("rstw_ok", 32'(mcu_ok), 32'd0);
    rst = 1'b0; mcu_cs = 1'b0; rom_ok = 1'b1; rom_data = 32'h12345678;
    step();
    step();
    rom_ok = 1'b0; mcu_cs = 1'b1;
    #1;
    chk("late_ok_ignored", 32'(mcu_ok), 32'd0);
    chk("late_ok_cs", 32'(rom_cs), 32'd0);
    mcu_cs = 1'b0;
    step();
`else
    // background prefetch wraps from the last line to line 0
    resp_en = 1'b1;
    mcu_addr = 16'hFFFC; mcu_cs = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mcu_ok) begin got = 1'b1; break; end
      step();
    end
    chk("pf_hit_ok", 32'(got), 32'd1);
    chk("pf_hit_data", 32'(mcu_data), 32'(model_byte(16'hFFFC, 2'd0)));
    step();
    chk("pf_req_cs", 32'(rom_cs), 32'd1);
    chk("pf_req_addr", 32'(rom_addr), 32'h0000);
    for (int c = 0; c < 40; c++) begin
      if (!rom_cs) break;
      step();
    end
    chk("pf_req_done", 32'(rom_cs), 32'd0);
    mcu_addr = 16'h0001;
    #1;
    chk("pf_line_ok", 32'(mcu_ok), 32'd1);
    chk("pf_line_data", 32'(mcu_data), 32'(model_byte(16'h0001, 2'd0)));
    step();
    chk("pf_no_new_req", 32'(rom_cs), 32'd0);
`endif

    // randomized traffic against the byte-level model
    resp_en = 1'b1;
    game_id = 2'd0; g = 2'd0; mcu_cs = 1'b0;
    step();
    prev = 16'h0000;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        g = 2'($urandom_range(0, 3));
        game_id = g; mcu_cs = 1'b0;
        step();
      end
      a = ($urandom_range(0, 1) == 1) ? prev + 16'($urandom_range(0, 7)) : 16'($urandom());
      mcu_addr = a; mcu_cs = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
        #1;
        if (mcu_ok) begin got = 1'b1; break; end
        step();
      end
      chk("rnd_ok", 32'(got), 32'd1);
      if (got) chk("rnd_data", 32'(mcu_data), 32'(model_byte(a, g)));
      prev = a;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
